// File: rtl/fence_sequencer.sv
// fence_sequencer
//
// Sequences fence-class instructions committed on port 0: waits for the
// store buffer to drain, optionally flushes the D$, then pulses the I$ or
// TLB flush as the instruction type requires, and finally acknowledges the
// commit with a one-cycle done_o (plus a pipeline flush).
//
// Request types: 00 FENCE, 01 FENCE_I, 10 SFENCE_VMA, 11 reserved (acked
// immediately, no flushes, no pipeline flush).
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset
//   halt_i             blocks acceptance of a new request while idle
//   req_valid_i        fence-class instruction present at commit port 0
//   req_type_i[1:0]    instruction type (see above)
//   no_st_pending_i    store buffer empty
//   dcache_flush_ack_i D$ flush complete
//   dcache_flush_o     D$ flush request (level, held until ack)
//   icache_flush_o     I$ flush, 1-cycle pulse
//   tlb_flush_o        TLB flush, 1-cycle pulse
//   done_o             commit ack, 1-cycle pulse
//   flush_pipeline_o   pipeline flush, coincident with done_o
//   busy_o             sequence in progress (any state but IDLE)
//   timeout_o          done_o was forced by the watchdog
//
// Build option
//   FENCE_SEQ_TIMEOUT_EN  when defined, a watchdog bounds the time spent in
//                         DRAIN+DFLUSH to TIMEOUT_CYCLES cycles; when not
//                         defined, those states wait indefinitely and
//                         timeout_o is constant 0.

module fence_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       halt_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_type_i,
    input  logic       no_st_pending_i,
    input  logic       dcache_flush_ack_i,
    output logic       dcache_flush_o,
    output logic       icache_flush_o,
    output logic       tlb_flush_o,
    output logic       done_o,
    output logic       flush_pipeline_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam logic [1:0] TYPE_FENCE   = 2'b00;
    localparam logic [1:0] TYPE_FENCE_I = 2'b01;
    localparam logic [1:0] TYPE_SFENCE  = 2'b10;
    localparam logic [1:0] TYPE_RSVD    = 2'b11;

    // Elaboration-time range check of the watchdog length.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("fence_sequencer: TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_DFLUSH,
        S_IFLUSH,
        S_TLB,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] type_q, type_d;
    logic       tmo_q, tmo_d;       // current DONE visit was forced by the watchdog
    logic       timeout_hit;

`ifdef FENCE_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q;

    // Counts cycles spent in DRAIN+DFLUSH; zero in the first DRAIN cycle,
    // so reaching TMO_LAST puts DONE exactly TIMEOUT_CYCLES after DRAIN entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_IDLE && state_d == S_DRAIN) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_DRAIN || state_q == S_DFLUSH) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign timeout_hit = (state_q == S_DRAIN || state_q == S_DFLUSH) &&
                         (tmo_cnt_q == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                tmo_d = 1'b0;
                if (req_valid_i && !halt_i) begin
                    type_d  = req_type_i;
                    state_d = (req_type_i == TYPE_RSVD) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Watchdog wins over a same-cycle normal exit.
                if (timeout_hit) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end else if (no_st_pending_i) begin
                    state_d = (type_q == TYPE_SFENCE) ? S_TLB : S_DFLUSH;
                end
            end
            S_DFLUSH: begin
                if (timeout_hit) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end else if (dcache_flush_ack_i) begin
                    state_d = (type_q == TYPE_FENCE_I) ? S_IFLUSH : S_DONE;
                end
            end
            S_IFLUSH: state_d = S_DONE;
            S_TLB:    state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                tmo_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are flopped decodes of the next state, so each one changes
    // in the same cycle as the state it represents and never glitches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dcache_flush_o   <= 1'b0;
            icache_flush_o   <= 1'b0;
            tlb_flush_o      <= 1'b0;
            done_o           <= 1'b0;
            flush_pipeline_o <= 1'b0;
            busy_o           <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            dcache_flush_o   <= (state_d == S_DFLUSH);
            icache_flush_o   <= (state_d == S_IFLUSH);
            tlb_flush_o      <= (state_d == S_TLB);
            done_o           <= (state_d == S_DONE);
            flush_pipeline_o <= (state_d == S_DONE) && (type_d != TYPE_RSVD);
            busy_o           <= (state_d != S_IDLE);
            timeout_o        <= (state_d == S_DONE) && tmo_d;
        end
    end

    // TYPE_FENCE documents the encoding; the FSM only distinguishes the others.
    logic type_is_fence;
    assign type_is_fence = (type_q == TYPE_FENCE);
    logic unused_type_is_fence;
    assign unused_type_is_fence = type_is_fence;

endmodule

// File: tb/tb_fence_sequencer.sv
module tb_fence_sequencer;

    logic       clk;
    logic       rst_i;
    logic       halt_i;
    logic       req_valid_i;
    logic [1:0] req_type_i;
    logic       no_st_pending_i;
    logic       dcache_flush_ack_i;
    logic       dcache_flush_o;
    logic       icache_flush_o;
    logic       tlb_flush_o;
    logic       done_o;
    logic       flush_pipeline_o;
    logic       busy_o;
    logic       timeout_o;

    int n_total = 0;
    int n_pass  = 0;

    // Observed vector: {dflush, iflush, tlb, done, flush_pipe, busy, timeout}
    logic [6:0] obs;
    assign obs = {dcache_flush_o, icache_flush_o, tlb_flush_o, done_o,
                  flush_pipeline_o, busy_o, timeout_o};

    localparam logic [6:0] Z   = 7'b0000000;
    localparam logic [6:0] B   = 7'b0000010;
    localparam logic [6:0] DF  = 7'b1000010;
    localparam logic [6:0] IFL = 7'b0100010;
    localparam logic [6:0] TL  = 7'b0010010;
    localparam logic [6:0] DN  = 7'b0001110;
    localparam logic [6:0] D11 = 7'b0001010;
    localparam logic [6:0] DT  = 7'b0001111;

    fence_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .halt_i             (halt_i),
        .req_valid_i        (req_valid_i),
        .req_type_i         (req_type_i),
        .no_st_pending_i    (no_st_pending_i),
        .dcache_flush_ack_i (dcache_flush_ack_i),
        .dcache_flush_o     (dcache_flush_o),
        .icache_flush_o     (icache_flush_o),
        .tlb_flush_o        (tlb_flush_o),
        .done_o             (done_o),
        .flush_pipeline_o   (flush_pipeline_o),
        .busy_o             (busy_o),
        .timeout_o          (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst_i = 1'b1; req_valid_i = 1'b1; req_type_i = 2'b00;
        no_st_pending_i = 1'b1; dcache_flush_ack_i = 1'b1; halt_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp = Z;
            n_total++;
            if (obs !== exp) $display("FAIL reset cycle %0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        rst_i = 1'b0; req_valid_i = 1'b0; no_st_pending_i = 1'b0; dcache_flush_ack_i = 1'b0;
        tick();
        n_total++;
        if (obs !== Z) $display("FAIL reset_release: got %b want %b", obs, Z);
        else n_pass++;
    endtask

    // FENCE, store buffer empty, ack already high when DFLUSH is entered.
    task automatic test_fence();
        logic [6:0] exp;
        no_st_pending_i = 1'b1; dcache_flush_ack_i = 1'b1;
        req_type_i = 2'b00; req_valid_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            req_valid_i = 1'b0;
            exp = (k == 1) ? B : (k == 2) ? DF : (k == 3) ? DN : Z;
            n_total++;
            if (obs !== exp) $display("FAIL fence cycle %0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        dcache_flush_ack_i = 1'b0; no_st_pending_i = 1'b0;
    endtask

    // FENCE_I, drain stalls, ack late; req_type_i changes mid-sequence.
    task automatic test_fence_i();
        logic [6:0] exp;
        no_st_pending_i = 1'b0; dcache_flush_ack_i = 1'b0;
        req_type_i = 2'b01; req_valid_i = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            req_valid_i = 1'b0;
            req_type_i = 2'b10;
            no_st_pending_i = (k >= 6);
            dcache_flush_ack_i = (k >= 10);
            exp = (k <= 6) ? B : (k <= 10) ? DF : (k == 11) ? IFL : (k == 12) ? DN : Z;
            n_total++;
            if (obs !== exp) $display("FAIL fence_i cycle %0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        no_st_pending_i = 1'b0; dcache_flush_ack_i = 1'b0; req_type_i = 2'b00;
    endtask

    // SFENCE_VMA held off by halt_i, then runs; halt_i ignored once busy.
    task automatic test_sfence_halt();
        logic [6:0] exp;
        halt_i = 1'b1; req_valid_i = 1'b1; req_type_i = 2'b10; no_st_pending_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_total++;
            if (obs !== Z) $display("FAIL sfence_halted cycle %0d: got %b want %b", k, obs, Z);
            else n_pass++;
        end
        halt_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            req_valid_i = 1'b0;
            halt_i = (k <= 2);
            exp = (k == 1) ? B : (k == 2) ? TL : (k == 3) ? DN : Z;
            n_total++;
            if (obs !== exp) $display("FAIL sfence cycle %0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        halt_i = 1'b0; no_st_pending_i = 1'b0; req_type_i = 2'b00;
    endtask

    // Reset while DFLUSH is pending; a late ack must not produce done_o.
    task automatic test_reset_dflush();
        logic [6:0] exp;
        no_st_pending_i = 1'b1; dcache_flush_ack_i = 1'b0;
        req_type_i = 2'b00; req_valid_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            req_valid_i = 1'b0;
            exp = (k == 1) ? B : DF;
            n_total++;
            if (obs !== exp) $display("FAIL rst_dflush pre cycle %0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        dcache_flush_ack_i = 1'b1;
        n_total++;
        if (obs !== Z) $display("FAIL rst_dflush after_reset: got %b want %b", obs, Z);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_total++;
            if (obs !== Z) $display("FAIL rst_dflush late_ack cycle %0d: got %b want %b", k, obs, Z);
            else n_pass++;
        end
        dcache_flush_ack_i = 1'b0; no_st_pending_i = 1'b0;
    endtask

    // Reserved type: immediate ack without pipeline flush.
    task automatic test_type11();
        logic [6:0] exp;
        req_type_i = 2'b11; req_valid_i = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            req_valid_i = 1'b0;
            exp = (k == 1) ? D11 : Z;
            n_total++;
            if (obs !== exp) $display("FAIL type11 cycle %0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        req_type_i = 2'b00;
    endtask

    // req_valid_i held across DONE restarts a sequence from the IDLE cycle.
    task automatic test_back_to_back();
        logic [6:0] exp;
        req_type_i = 2'b11; req_valid_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 3) req_valid_i = 1'b0;
            exp = (k == 1 || k == 3) ? D11 : Z;
            n_total++;
            if (obs !== exp) $display("FAIL back_to_back cycle %0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        req_type_i = 2'b00;
    endtask

    // FENCE whose D$ flush is never acknowledged.
    task automatic test_timeout();
        logic [6:0] exp;
        no_st_pending_i = 1'b0; dcache_flush_ack_i = 1'b0;
        req_type_i = 2'b00; req_valid_i = 1'b1;
`ifdef FENCE_SEQ_TIMEOUT_EN
        for (int k = 1; k <= 10; k++) begin
            tick();
            req_valid_i = 1'b0;
            no_st_pending_i = (k >= 3);
            exp = (k <= 3) ? B : (k <= 8) ? DF : (k == 9) ? DT : Z;
            n_total++;
            if (obs !== exp) $display("FAIL timeout cycle %0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
`else
        for (int k = 1; k <= 20; k++) begin
            tick();
            req_valid_i = 1'b0;
            no_st_pending_i = (k >= 3);
            exp = (k <= 3) ? B : DF;
            n_total++;
            if (obs !== exp) $display("FAIL no_timeout cycle %0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
`endif
        no_st_pending_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; halt_i = 1'b0; req_valid_i = 1'b0; req_type_i = 2'b00;
        no_st_pending_i = 1'b0; dcache_flush_ack_i = 1'b0;
        test_reset();
        test_fence();
        test_fence_i();
        test_sfence_halt();
        test_reset_dflush();
        test_type11();
        test_back_to_back();
        test_timeout();
        tick();
        n_total++;
        if (obs !== Z) $display("FAIL final_idle: got %b want %b", obs, Z);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fence_sequencer.md
FENCE_SEQUENCER -- requirements
Module: fence_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the max cycles spent in DRAIN+DFLUSH before forced completion (range 2..65535).
REQ-002 SHALL have port clk_i  input  1  clock; the block uses one clock, rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port halt_i  input  1  halt request; blocks acceptance in IDLE only.
REQ-005 SHALL have port req_valid_i  input  1  fence-class instruction at commit port 0.
REQ-006 SHALL have port req_type_i  input  2  00 FENCE, 01 FENCE_I, 10 SFENCE_VMA, 11 reserved.
REQ-007 SHALL have port no_st_pending_i  input  1  store buffer empty.
REQ-008 SHALL have port dcache_flush_ack_i  input  1  D$ flush complete.
REQ-009 SHALL have port dcache_flush_o  output  1  D$ flush request; level.
REQ-010 SHALL have port icache_flush_o  output  1  I$ flush; 1-cycle pulse.
REQ-011 SHALL have port tlb_flush_o  output  1  TLB flush; 1-cycle pulse.
REQ-012 SHALL have port done_o  output  1  commit ack for port 0; 1-cycle pulse.
REQ-013 SHALL have port flush_pipeline_o  output  1  pipeline flush; 1-cycle pulse, coincident with done_o.
REQ-014 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-015 SHALL have port timeout_o  output  1  forced completion flag; valid with done_o.

Function
REQ-016 SHALL implement states IDLE, DRAIN, DFLUSH, IFLUSH, TLB, DONE; all outputs are registered state decodes.
REQ-017 IDLE: when req_valid_i=1 and halt_i=0, SHALL latch req_type_i and enter DRAIN next cycle (types 00/01/10) or DONE (type 11).
REQ-018 DRAIN: SHALL stay while no_st_pending_i=0; when 1, go to DFLUSH (00/01) or TLB (10).
REQ-019 DFLUSH: SHALL hold dcache_flush_o=1; on dcache_flush_ack_i=1 go to IFLUSH (01) or DONE (00).
REQ-020 IFLUSH and TLB SHALL each last exactly one cycle, asserting icache_flush_o / tlb_flush_o, then go to DONE.
REQ-021 DONE SHALL last one cycle with done_o=1 and flush_pipeline_o=1 (flush_pipeline_o=0 for type 11), then return to IDLE.
REQ-022 Minimum latencies, accept cycle = 0, done_o in: FENCE cycle 3, FENCE_I cycle 4, SFENCE_VMA cycle 3, type 11 cycle 1.
REQ-023 req_valid_i, req_type_i and halt_i SHALL be ignored outside IDLE; deasserting req_valid_i mid-sequence does not abort it.
REQ-024 The cycle after DONE is IDLE; a still-asserted req_valid_i there SHALL start a new sequence (the requester drops it on done_o).
REQ-025 dcache_flush_ack_i outside DFLUSH and no_st_pending_i outside DRAIN SHALL be ignored.
REQ-026 Exactly one of dcache_flush_o, icache_flush_o, tlb_flush_o, done_o SHALL be high in any cycle, or none.

Reset
REQ-027 rst_i=1 at a rising edge SHALL force IDLE; all outputs 0 from the following cycle, including mid-DFLUSH (dcache_flush_o drops without ack).
REQ-028 Latched type and timeout counter SHALL clear to 0 on reset.

Configuration
REQ-029 Macro FENCE_SEQ_TIMEOUT_EN defined: a counter, cleared on entering DRAIN, increments each cycle in DRAIN/DFLUSH; at TIMEOUT_CYCLES-1 the FSM SHALL go to DONE with timeout_o=1, skipping remaining flush stages.
REQ-030 FENCE_SEQ_TIMEOUT_EN undefined: no counter is instantiated, timeout_o tied 0, DRAIN/DFLUSH wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-031 FENCE, no_st_pending_i=1, ack same cycle as DFLUSH entry -> dcache_flush_o cycle 2 only, done_o+flush_pipeline_o cycle 3.
REQ-032 FENCE_I, no_st_pending_i low 5 cycles, ack after 3 DFLUSH cycles -> icache_flush_o one cycle, then done_o; no tlb_flush_o.
REQ-033 SFENCE_VMA with halt_i=1 for 4 cycles -> no acceptance until halt_i=0; then tlb_flush_o cycle 2, done_o cycle 3 after acceptance.
REQ-034 rst_i asserted in DFLUSH -> dcache_flush_o, busy_o 0 next cycle; late ack ignored; no done_o.
REQ-035 With FENCE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack never given -> done_o=timeout_o=1 exactly 8 cycles after DRAIN entry; without macro busy_o stays 1.
REQ-036 Type 11 request -> done_o cycle 1, flush_pipeline_o=0, no flush outputs.
